// File: rtl/kb_tx_arbiter.sv
// Shares the UART TX FIFO write port between keyboard bytes and atomic message packets (round-robin, CR -> CR+LF).
// Latency: zero cycles; a granted byte is written in the same cycle its pop/ack is issued.
// Backpressure: tx_full stalls everything (no write, pop or ack); sources hold their byte until served.
module kb_tx_arbiter #(
    parameter int W       = 8,
    parameter bit CRLF_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         kb_buf_empty,
    input  logic [W-1:0] kb_data,
    output logic         rd_key_code,
    input  logic         msg_req,
    input  logic [W-1:0] msg_data,
    input  logic         msg_last,
    output logic         msg_ack,
    input  logic         tx_full,
    output logic         wr_uart,
    output logic [W-1:0] w_data,
    output logic         busy,
    output logic [15:0]  tx_count
);

    typedef enum logic [1:0] {S_IDLE, S_LF, S_MSG} state_t;
    typedef enum logic {SRC_KB, SRC_MSG} src_t;

    localparam logic [W-1:0] CR_BYTE = W'(8'h0D);
    localparam logic [W-1:0] LF_BYTE = W'(8'h0A);

    state_t state, state_nxt;
    src_t   last, last_nxt;
    logic   grant_kb, grant_msg, lf_wr;
    logic   can_move;

    // Nothing moves while the FIFO is full, and reset silences every strobe immediately.
    assign can_move = reset && !tx_full;

    // State, round-robin owner, busy flag and write counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            last     <= SRC_MSG;
            busy     <= 1'b0;
            tx_count <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            busy  <= (state_nxt != S_IDLE);
            if (wr_uart) begin
                tx_count <= tx_count + 16'd1;
            end
        end
    end

    // Next state and round-robin update, driven by which source won the port this cycle.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            S_IDLE: begin
                if (grant_kb) begin
                    last_nxt = SRC_KB;
                    if (CRLF_EN && (kb_data == CR_BYTE)) begin
                        state_nxt = S_LF;
                    end
                end else if (grant_msg) begin
                    if (msg_last) begin
                        last_nxt = SRC_MSG;
                    end else begin
                        state_nxt = S_MSG;
                    end
                end
            end
            S_LF: begin
                if (lf_wr) begin
                    state_nxt = S_IDLE;
                end
            end
            S_MSG: begin
                if (grant_msg && msg_last) begin
                    state_nxt = S_IDLE;
                    last_nxt  = SRC_MSG;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Mealy grant and write-port outputs; a contested grant goes to the source that did not go last.
    always_comb begin
        grant_kb    = 1'b0;
        grant_msg   = 1'b0;
        lf_wr       = 1'b0;
        if (can_move) begin
            case (state)
                S_IDLE: begin
                    if (!kb_buf_empty && msg_req) begin
                        grant_kb  = (last == SRC_MSG);
                        grant_msg = (last == SRC_KB);
                    end else begin
                        grant_kb  = !kb_buf_empty;
                        grant_msg = msg_req;
                    end
                end
                S_LF:    lf_wr     = 1'b1;
                S_MSG:   grant_msg = msg_req;
                default: ;
            endcase
        end
        rd_key_code = grant_kb;
        msg_ack     = grant_msg;
        wr_uart     = grant_kb || grant_msg || lf_wr;
        if (grant_kb) begin
            w_data = kb_data;
        end else if (grant_msg) begin
            w_data = msg_data;
        end else if (lf_wr) begin
            w_data = LF_BYTE;
        end else begin
            w_data = '0;
        end
    end

endmodule
